// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter.
// Command codes, FSM state encoding, tag constants and default timing.
package sdram_pkg;

    localparam int TAG_W = 2;

    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [1:0] ST_WAIT_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_ISSUE      = 2'd2;
    localparam logic [1:0] ST_WAIT_REPLY = 2'd3;

    typedef enum logic [1:0] {
        S_WAIT_INIT  = ST_WAIT_INIT,
        S_IDLE       = ST_IDLE,
        S_ISSUE      = ST_ISSUE,
        S_WAIT_REPLY = ST_WAIT_REPLY
    } arb_state_t;

    localparam logic [TAG_W-1:0] REQ0_TAG = 2'b00;
    localparam logic [TAG_W-1:0] REQ1_TAG = 2'b01;
    localparam logic [TAG_W-1:0] REQ2_TAG = 2'b10;
    localparam logic [TAG_W-1:0] REF_TAG  = 2'b11;

    localparam int DEF_REF_INTERVAL = 780;
    localparam int DEF_TIMEOUT_CYC  = 1024;

endpackage

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr.
// Returns a one-hot grant, the winning index and an any-request flag.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // scan from the pointer with wraparound, first hit wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Shares the SDRAM controller command port between NUM_REQ sources
// with periodic refresh injection. Optional reply watchdog: SDRAM_ARB_TIMEOUT_EN.
module sdram_cmd_arbiter
    import sdram_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter int         REF_INTERVAL = DEF_REF_INTERVAL,
`ifdef SDRAM_ARB_TIMEOUT_EN
    parameter int         TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
`endif
    parameter logic [3:0] REF_CMD      = CMD_REF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_comp,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [3:0]           cmd,
    output logic                 cmd_valid,
    output logic [TAG_W-1:0]     cmd_tag,
    input  logic                 reply,
    output logic                 ref_pending
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int RC_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REF_INTERVAL - 1);
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t state, state_n;
    logic [TAG_W-1:0] ptr, ptr_n;
    logic [RC_W-1:0] rcnt, rcnt_n;
    logic pend_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic [3:0] cmd_n;
    logic cmd_valid_n;
    logic [TAG_W-1:0] tag_n;
    logic src_ref, src_ref_n;
    logic ref_clr;
    logic finish;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [TAG_W-1:0] pick_idx;
    logic pick_any;

    rr_pick #(
        .N(NUM_REQ),
        .W(TAG_W)
    ) u_pick (
        .req(req),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tcnt, tcnt_n;
    logic to_fire;

    assign to_fire = init_comp && (state == S_WAIT_REPLY) && !reply
                     && (tcnt == TC_LAST);

    // watchdog counts cycles spent waiting for a reply
    always_comb begin
        tcnt_n = '0;
        if (state == S_WAIT_REPLY && !reply) begin
            tcnt_n = tcnt + 1'b1;
        end
    end

    // watchdog counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            timeout_err <= timeout_err | to_fire;
        end
    end
`endif

    // command FSM: next state and registered output values
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_n     = '0;
        done_n      = '0;
        cmd_n       = cmd;
        cmd_valid_n = cmd_valid;
        tag_n       = cmd_tag;
        src_ref_n   = src_ref;
        ref_clr     = 1'b0;
        finish      = 1'b0;
        unique case (state)
            S_WAIT_INIT: begin
                if (init_comp) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (ref_pending) begin
                    cmd_n     = REF_CMD;
                    tag_n     = REF_TAG;
                    src_ref_n = 1'b1;
                    state_n   = S_ISSUE;
                end else if (pick_any) begin
                    cmd_n     = req_cmd[{pick_idx, 2'b00} +: 4];
                    tag_n     = pick_idx;
                    src_ref_n = 1'b0;
                    grant_n   = pick_gnt;
                    ptr_n     = (pick_idx == LAST_IDX) ? '0
                                                       : pick_idx + 1'b1;
                    state_n   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_valid_n = 1'b1;
                state_n     = S_WAIT_REPLY;
            end
            S_WAIT_REPLY: begin
                finish = reply;
`ifdef SDRAM_ARB_TIMEOUT_EN
                finish = reply | to_fire;
`endif
                if (finish) begin
                    cmd_valid_n = 1'b0;
                    state_n     = S_IDLE;
                    if (src_ref) begin
                        ref_clr = reply;
                    end else begin
                        done_n = ONE << cmd_tag;
                    end
                end
            end
            default: begin
                state_n = S_WAIT_INIT;
            end
        endcase
        // losing init aborts everything except the round-robin pointer
        if (!init_comp) begin
            state_n     = S_WAIT_INIT;
            cmd_valid_n = 1'b0;
            grant_n     = '0;
            done_n      = '0;
            ref_clr     = 1'b0;
        end
    end

    // refresh interval counter; a new owed refresh wins over a clear
    always_comb begin
        rcnt_n = '0;
        pend_n = 1'b0;
        if (init_comp) begin
            rcnt_n = (rcnt == RC_LAST) ? '0 : rcnt + 1'b1;
            pend_n = ref_pending & ~ref_clr;
            if (rcnt == RC_LAST) begin
                pend_n = 1'b1;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_INIT;
            ptr         <= '0;
            rcnt        <= '0;
            ref_pending <= 1'b0;
            grant       <= '0;
            done        <= '0;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            cmd_tag     <= '0;
            src_ref     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            rcnt        <= rcnt_n;
            ref_pending <= pend_n;
            grant       <= grant_n;
            done        <= done_n;
            cmd         <= cmd_n;
            cmd_valid   <= cmd_valid_n;
            cmd_tag     <= tag_n;
            src_ref     <= src_ref_n;
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter (REF_INTERVAL=20).
// With SDRAM_ARB_TIMEOUT_EN the watchdog path is exercised too.
module tb_sdram_cmd_arbiter;
    import sdram_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_comp = 1'b0;
    logic reply = 1'b0;
    logic [N-1:0] req = '0;
    logic [4*N-1:0] req_cmd = 16'h3452;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic [3:0] cmd;
    logic cmd_valid;
    logic [1:0] cmd_tag;
    logic ref_pending;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sdram_cmd_arbiter #(
        .NUM_REQ(N),
        .REF_INTERVAL(20),
`ifdef SDRAM_ARB_TIMEOUT_EN
        .TIMEOUT_CYC(16),
`endif
        .REF_CMD(4'b0001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init_comp(init_comp),
        .req(req),
        .req_cmd(req_cmd),
        .grant(grant),
        .done(done),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .cmd_tag(cmd_tag),
        .reply(reply),
        .ref_pending(ref_pending)
`ifdef SDRAM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        int order[5] = '{0, 1, 2, 3, 0};
        int g, wc, nd, ref_tick, nbad;
        bit exp_done, ref_cmd_seen, ref_reply, pend_clr;
        bit prev_valid, prev_grant;
        logic [3:0] ccmd;
        logic [1:0] ctag;

        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_tag", cmd_tag, 0);
        chk("rst_pend", ref_pending, 0);
        rst = 1'b0;

        // 1: traffic held until init
        req = 4'b0001;
        seen = 1'b0;
        repeat (50) begin
            tick();
            seen = seen | cmd_valid | (|grant);
        end
        chk("t1_hold", seen, 0);
        init_comp = 1'b1;
        tick();
        chk("t1_idle_nogrant", grant, 0);
        tick();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_cmd", cmd, 4'h2);
        chk("t1_valid_early", cmd_valid, 0);
        req = '0;
        tick();
        chk("t1_valid", cmd_valid, 1);
        chk("t1_tag", cmd_tag, 0);
        chk("t1_grant_pulse", grant, 0);
        reply = 1'b1;
        tick();
        reply = 1'b0;
        chk("t1_done", done, 4'b0001);
        chk("t1_valid_clr", cmd_valid, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // 2: all requesting, replies 3 cycles after cmd_valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        g = 0;
        wc = -1;
        nd = 0;
        exp_done = 1'b0;
        ccmd = '0;
        ctag = '0;
        for (int c = 0; c < 150; c++) begin
            tick();
            reply = 1'b0;
            if (exp_done) begin
                exp_done = 1'b0;
                if (ccmd == 4'b0001) begin
                    chk("t2_ref_nodone", done, 0);
                end else begin
                    chk("t2_done", done, 4'(1) << ctag);
                    nd++;
                end
            end else if (done != 0) begin
                chk("t2_stray_done", done, 0);
            end
            if (grant != 0) begin
                if (g < 5) chk("t2_grant", grant, 4'(1) << order[g]);
                else chk("t2_extra_grant", grant, 0);
                g++;
                if (g == 5) req = '0;
            end
            if (cmd_valid && wc < 0) begin
                ccmd = cmd;
                ctag = cmd_tag;
                wc = 3;
            end
            if (wc > 0) begin
                wc--;
                if (wc == 0) begin
                    reply = 1'b1;
                    exp_done = 1'b1;
                    wc = -1;
                end
            end
        end
        chk("t2_ngrant", g, 5);
        chk("t2_ndone", nd, 5);

        // 3: refresh owed after 20 cycles, served before further grants
        init_comp = 1'b0;
        reply = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        chk("t3_pend_clr", ref_pending, 0);
        init_comp = 1'b1;
        ref_tick = 0;
        nbad = 0;
        ref_cmd_seen = 1'b0;
        ref_reply = 1'b0;
        pend_clr = 1'b0;
        prev_valid = 1'b0;
        prev_grant = 1'b0;
        for (int c = 1; c <= 60 && !pend_clr; c++) begin
            tick();
            if (ref_reply) begin
                chk("t3_pend_reply", ref_pending, 0);
                pend_clr = 1'b1;
            end
            ref_reply = 1'b0;
            reply = 1'b0;
            if (ref_pending && ref_tick == 0) ref_tick = c;
            if (ref_tick != 0 && c > ref_tick && !ref_cmd_seen && grant != 0)
                nbad++;
            if (cmd_valid && !prev_valid && ref_tick != 0 && !ref_cmd_seen
                && !prev_grant) begin
                chk("t3_ref_cmd", cmd, 4'b0001);
                chk("t3_ref_tag", cmd_tag, 2'b11);
                ref_cmd_seen = 1'b1;
            end
            if (cmd_valid && !pend_clr) begin
                reply = 1'b1;
                ref_reply = ref_cmd_seen && (cmd == 4'b0001);
            end
            prev_valid = cmd_valid;
            prev_grant = |grant;
        end
        req = '0;
        reply = 1'b0;
        chk("t3_ref_cycle", ref_tick, 20);
        chk("t3_grants_before_ref", nbad, 0);
        chk("t3_ref_seen", ref_cmd_seen, 1);
        chk("t3_pend_done", pend_clr, 1);

        // 4: init lost mid-command
        init_comp = 1'b0;
        tick();
        tick();
        req = 4'b0100;
        init_comp = 1'b1;
        tick();
        tick();
        chk("t4_grant", grant, 4'b0100);
        tick();
        chk("t4_valid", cmd_valid, 1);
        init_comp = 1'b0;
        tick();
        chk("t4_valid_drop", cmd_valid, 0);
        chk("t4_no_done", done, 0);
        reply = 1'b1;
        tick();
        chk("t4_reply_ignored", done, 0);
        reply = 1'b0;
        init_comp = 1'b1;
        tick();
        chk("t4_idle_nogrant", grant, 0);
        tick();
        chk("t4_regrant", grant, 4'b0100);
        tick();
        chk("t4_cmd", cmd, 4'h4);
        reply = 1'b1;
        tick();
        chk("t4_done", done, 4'b0100);
        reply = 1'b0;
        req = '0;

        // 5: stray reply in IDLE, then req dropped after grant
        reply = 1'b1;
        tick();
        chk("t5_stray_done", done, 0);
        chk("t5_stray_valid", cmd_valid, 0);
        chk("t5_stray_grant", grant, 0);
        reply = 1'b0;
        req = 4'b0100;
        tick();
        chk("t5_grant", grant, 4'b0100);
        req = '0;
        tick();
        chk("t5_valid", cmd_valid, 1);
        chk("t5_tag", cmd_tag, 2);
        tick();
        chk("t5_valid_hold", cmd_valid, 1);
        reply = 1'b1;
        tick();
        chk("t5_done", done, 4'b0100);
        reply = 1'b0;
        tick();
        chk("t5_done_pulse", done, 0);

        // reset while a command is outstanding
        req = 4'b0001;
        tick();
        chk("rst2_grant", grant, 4'b0001);
        req = '0;
        tick();
        chk("rst2_valid", cmd_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst2_abort", cmd_valid, 0);
        chk("rst2_no_done", done, 0);
        tick();
        rst = 1'b0;

`ifdef SDRAM_ARB_TIMEOUT_EN
        // 6: no reply, watchdog releases the requester
        init_comp = 1'b0;
        tick();
        tick();
        req = 4'b0001;
        init_comp = 1'b1;
        tick();
        tick();
        chk("t6_grant", grant, 4'b0001);
        req = '0;
        tick();
        chk("t6_valid", cmd_valid, 1);
        repeat (15) tick();
        chk("t6_no_err_yet", timeout_err, 0);
        chk("t6_still_valid", cmd_valid, 1);
        tick();
        chk("t6_err", timeout_err, 1);
        chk("t6_done", done, 4'b0001);
        chk("t6_valid_clr", cmd_valid, 0);
        req = 4'b0010;
        tick();
        chk("t6_idle_grant", grant, 4'b0010);
        req = '0;
        tick();
        tick();
        chk("t6_sticky", timeout_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
Shares the single command port of the SDRAM controller between NUM_REQ command sources, for example the init/test sequencer and the particle-state readback engine.
- Holds all traffic until the controller reports initialisation complete.
- Grants requesters round-robin and forwards one 4-bit command at a time.
- Waits for the controller's reply pulse before the next command is issued.
- Injects periodic auto-refresh commands at higher priority than any requester.

Parameters:
NUM_REQ, 4, number of requesters (2..4); tag width is 2 bits.
REF_INTERVAL, 780, cycles between refresh requests (7.8 us at 100 MHz).
REF_CMD, 4'b0001, command code driven for auto-refresh.
TIMEOUT_CYC, 1024, reply watchdog limit; used only with the optional feature.

Ports:
clk  in  1  100 MHz system clock, same clock as the controller.
rst  in  1  asynchronous, active-high reset.
init_comp  in  1  controller initialisation done; level signal.
req  in  NUM_REQ  per-requester command request; level, held until grant.
req_cmd  in  4*NUM_REQ  command code for each requester; requester i uses bits [4i+3:4i].
grant  out  NUM_REQ  one-hot; one-cycle pulse when a requester's command is latched.
done  out  NUM_REQ  one-hot; one-cycle pulse when that requester's command completes.
cmd  out  4  command to the controller.
cmd_valid  out  1  command present; held until reply.
cmd_tag  out  2  source of the current command: requester index, or 2'b11 for refresh when NUM_REQ is less than 4.
reply  in  1  controller one-cycle completion pulse.
ref_pending  out  1  a refresh is owed.
timeout_err  out  1  sticky watchdog flag; present only with the optional feature.

Behaviour:
- Reset values: all outputs 0; state WAIT_INIT; round-robin pointer 0; refresh counter 0.
- Outputs are registered.
- States and transitions:
  - WAIT_INIT: stay while init_comp is 0, otherwise go to IDLE.
  - IDLE, refresh owed: if ref_pending is 1, latch REF_CMD and go to ISSUE.
  - IDLE, requests present: else if any req bit is 1, pick the first set bit at or after the pointer (wrap at NUM_REQ). Latch its cmd and index, pulse its grant bit for 1 cycle, and set the pointer to index+1 mod NUM_REQ.
  - ISSUE: drive cmd_valid=1 with the latched cmd/tag, then go to WAIT_REPLY.
  - WAIT_REPLY: hold cmd_valid, cmd and cmd_tag stable. On reply, clear cmd_valid. If the source was a requester, pulse its done bit; if it was refresh, clear ref_pending. Go to IDLE.
- Latency: req is seen in IDLE at edge N; grant is high and the state is ISSUE after edge N; cmd_valid is high after edge N+1. done rises on the edge that samples reply. The earliest next grant is 1 cycle after done.
- Refresh counter:
  - Runs only once init_comp is 1.
  - At REF_INTERVAL-1 it wraps to 0 and sets ref_pending.
  - If a refresh is already pending at the wrap, the new one is not queued twice (saturating).
- Requester timing: a requester may drop req after its grant. The latched command still completes and done still pulses.
- Unexpected reply: a reply outside WAIT_REPLY is ignored.
- init_comp falls in any state other than WAIT_INIT: go to WAIT_INIT on the next edge. Clear cmd_valid, issue no done, clear ref_pending and the counter. The round-robin pointer is kept.
- Reset mid-command: abort immediately; no done.
- Contention: with simultaneous req from all sources, no requester waits longer than NUM_REQ grants plus pending refreshes.

Optional Feature:
SDRAM_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_REPLY. At TIMEOUT_CYC cycles without reply, set timeout_err (sticky until rst) and clear cmd_valid.
  - Pulse done for a requester source to release it; a refresh source stays pending. Then return to IDLE.
  - The timeout_err port exists.
- Undefined: no counter and no timeout_err port; WAIT_REPLY waits forever.

Decomposition:
- Package sdram_pkg:
  - Command codes: NOP, ACT, RD, WR, PRE, REF, MRS.
  - State encoding localparams.
  - Tag constants, including REF_TAG=2'b11.
  - Default REF_INTERVAL.
- Sub-module rr_pick: combinational round-robin selector taking req and pointer and returning a one-hot grant plus index. It is reused by later bus arbiters.

Test Plan:
1. init_comp=0 for 50 cycles with req=4'b0001 -> cmd_valid stays 0; after init_comp=1, grant=0001 in the next IDLE cycle and cmd_valid=1 two edges later.
2. req=4'b1111 held, reply 3 cycles after each cmd_valid -> grants in order 0,1,2,3,0; each done is one-hot and matches cmd_tag.
3. REF_INTERVAL=20 with continuous req=4'b0010 -> ref_pending sets at cycle 20; the next command has cmd=4'b0001 and tag 2'b11; ref_pending clears on its reply.
4. Deassert init_comp during WAIT_REPLY -> cmd_valid=0 the next edge and no done pulse; re-assert init_comp and the pending req is re-granted.
5. Spurious reply in IDLE, then req[2] dropped right after grant -> the stray reply has no effect; the command completes and done[2] pulses.
6. With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no reply -> timeout_err=1 at cycle 16 of WAIT_REPLY, done pulses for the requester, and the state returns to IDLE.
